toggle_pulse_scheduler: RTL and testbench

Source-domain scheduler that shares one toggle-synchronizer channel among several event requesters. It counts pending events per requester and arbitrates round-robin between them. Each issue is a single-cycle pulse, with a guaranteed minimum spacing so that the destination domain sees every toggle. It sits in the write clock domain, directly upstream of the toggle synchronizer's `wr_data` input, and presents a held requester ID alongside each pulse.

---
 rtl/toggle_pulse_scheduler.sv | 112 +++++++++++
 tb/tb_toggle_pulse_scheduler.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_pulse_scheduler.sv
// Round-robin scheduler feeding one toggle-synchronizer channel with spaced,
// single-cycle pulses. It keeps a saturating pending-event counter per requester.
//
// state | meaning
// IDLE  | waiting for pending events; grants when en=1
// HOLD  | pulse issued; enforcing GAP-cycle spacing before the next decision
module toggle_pulse_scheduler #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 6,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             wr_clk,
    input  logic             wr_reset,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] ovf_clr,
    output logic             tx_pulse,
    output logic [ID_W-1:0]  tx_id,
    output logic             busy,
    output logic [N_REQ-1:0] pend_nz,
    output logic [N_REQ-1:0] ovf
);

    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                       state;
    logic [N_REQ-1:0][CNT_W-1:0]  cnt;
    logic [GAP_W-1:0]             gap_cnt;
    logic [ID_W-1:0]              last;
    logic                         grant_vld;
    logic [ID_W-1:0]              grant_id;
    logic [N_REQ-1:0]             grant_vec;

    for (genvar g = 0; g < N_REQ; g++) begin : g_pend
        assign pend_nz[g] = |cnt[g];
    end

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_id  = '0;
        if (state == IDLE && en) begin
            for (int k = 1; k <= N_REQ; k++) begin
                idx = (int'(last) + k) % N_REQ;
                if (!grant_vld && pend_nz[idx]) begin
                    grant_vld = 1'b1;
                    grant_id  = ID_W'(idx);
                end
            end
        end
        grant_vec = grant_vld ? (N_REQ'(1) << grant_id) : '0;
    end

    always_ff @(posedge wr_clk or posedge wr_reset) begin
        if (wr_reset) begin
            cnt <= '0;
            ovf <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && !grant_vec[i]) begin
                    if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
                end else if (!req[i] && grant_vec[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
                // A new overflow beats a clear arriving in the same cycle.
                if (req[i] && !grant_vec[i] && cnt[i] == CNT_MAX) ovf[i] <= 1'b1;
                else if (ovf_clr[i])                               ovf[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge wr_clk or posedge wr_reset) begin
        if (wr_reset) begin
            state    <= IDLE;
            tx_pulse <= 1'b0;
            tx_id    <= '0;
            busy     <= 1'b0;
            last     <= ID_W'(N_REQ - 1);
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_pulse <= grant_vld;
                    if (grant_vld) begin
                        tx_id   <= grant_id;
                        last    <= grant_id;
                        gap_cnt <= GAP_W'(GAP - 1);
                        busy    <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    tx_pulse <= 1'b0;
                    if (gap_cnt == GAP_W'(1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_pulse_scheduler.sv
// Scenario bench for toggle_pulse_scheduler: directed cases plus randomized
// traffic against a timing-rule reference model.
module tb_toggle_pulse_scheduler;
    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int GAP  = 6;
    localparam int IW   = 2;
    localparam int MAXC = 15;

    logic          wr_clk = 1'b0;
    logic          wr_reset;
    logic          en;
    logic [N-1:0]  req;
    logic [N-1:0]  ovf_clr;
    logic          tx_pulse;
    logic [IW-1:0] tx_id;
    logic          busy;
    logic [N-1:0]  pend_nz;
    logic [N-1:0]  ovf;

    always #5 wr_clk = ~wr_clk;

    toggle_pulse_scheduler #(.N_REQ(N), .CNT_W(CW), .GAP(GAP)) dut (
        .wr_clk(wr_clk), .wr_reset(wr_reset), .en(en), .req(req), .ovf_clr(ovf_clr),
        .tx_pulse(tx_pulse), .tx_id(tx_id), .busy(busy), .pend_nz(pend_nz), .ovf(ovf)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: event counts plus the cycle of the latest pulse.
    int           m_cnt [N];
    logic [N-1:0] m_ovf;
    int           m_last;
    int           m_pulse_cyc;
    int           m_id;
    int           cyc = 0;

    function automatic logic [N-1:0] m_pend();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = (m_cnt[i] != 0);
        return p;
    endfunction

    function automatic logic m_pulse();
        return cyc == m_pulse_cyc;
    endfunction

    function automatic logic m_busy();
        return (cyc >= m_pulse_cyc) && (cyc <= m_pulse_cyc + GAP - 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ovf       = '0;
        m_last      = N - 1;
        m_pulse_cyc = -100;
        m_id        = 0;
    endtask

    task automatic tick();
        bit g;
        int w;
        int idx;
        bit gi;
        bit sat;
        g = 0;
        w = 0;
        if (wr_reset) begin
            model_reset();
        end else begin
            if (en && (m_pend() != '0) && cyc >= m_pulse_cyc + GAP - 1) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (!g && m_cnt[idx] != 0) begin
                        g = 1;
                        w = idx;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                gi  = g && (w == i);
                sat = 0;
                if (req[i] && !gi) begin
                    if (m_cnt[i] == MAXC) sat = 1;
                    else m_cnt[i]++;
                end else if (!req[i] && gi) begin
                    m_cnt[i]--;
                end
                if (sat) m_ovf[i] = 1'b1;
                else if (ovf_clr[i]) m_ovf[i] = 1'b0;
            end
            if (g) begin
                m_pulse_cyc = cyc + 1;
                m_id        = w;
                m_last      = w;
            end
        end
        @(posedge wr_clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        wr_reset = 1'b1;
        en       = 1'b1;
        req      = '0;
        ovf_clr  = '0;
        model_reset();
        tick();
        tick();
        wr_reset = 1'b0;
    endtask

    task automatic test_reset();
        wr_reset = 1'b1;
        en       = 1'b1;
        req      = '0;
        ovf_clr  = '0;
        model_reset();
        tick();
        n_cmp++;
        if ({tx_pulse, tx_id, busy, pend_nz, ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got pulse=%b id=%0d busy=%b pend=%b ovf=%b, want all 0",
                     tx_pulse, tx_id, busy, pend_nz, ovf);
        end
        tick();
        wr_reset = 1'b0;
        tick();
        n_cmp++;
        if ({tx_pulse, busy, pend_nz} !== '0) begin
            n_err++;
            $display("FAIL reset_release_idle: got pulse=%b busy=%b pend=%b, want 0",
                     tx_pulse, busy, pend_nz);
        end
    endtask

    task automatic test_single();
        int t;
        do_reset();
        req = 4'b0001;
        t   = cyc;
        tick();
        req = '0;
        n_cmp++;
        if (pend_nz !== 4'b0001 || tx_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL single_t1: got pend=%b pulse=%b, want 0001/0", pend_nz, tx_pulse);
        end
        tick();
        n_cmp++;
        if (tx_pulse !== 1'b1 || tx_id !== 2'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_t2: got pulse=%b id=%0d busy=%b, want 1/0/1", tx_pulse, tx_id, busy);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (tx_pulse !== 1'b0 || pend_nz !== '0 || busy !== (cyc <= t + 6)) begin
                n_err++;
                $display("FAIL single_after cyc+%0d: got pulse=%b pend=%b busy=%b, want 0/0000/%b",
                         cyc - t, tx_pulse, pend_nz, busy, cyc <= t + 6);
            end
        end
    endtask

    task automatic test_round_robin();
        int t;
        int npulse;
        do_reset();
        req    = 4'b1111;
        t      = cyc;
        npulse = 0;
        tick();
        req = '0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (tx_pulse === 1'b1) begin
                n_cmp++;
                if (cyc != t + 2 + GAP * npulse || tx_id !== IW'(npulse)) begin
                    n_err++;
                    $display("FAIL rr_pulse%0d: got cyc+%0d id=%0d, want cyc+%0d id=%0d",
                             npulse, cyc - t, tx_id, 2 + GAP * npulse, npulse);
                end
                npulse++;
            end
            n_cmp++;
            if ({tx_pulse, tx_id, busy, pend_nz, ovf} !== {m_pulse(), IW'(m_id), m_busy(), m_pend(), m_ovf}) begin
                n_err++;
                $display("FAIL rr_model cyc+%0d: got %b %0d %b %b %b, want %b %0d %b %b %b", cyc - t,
                         tx_pulse, tx_id, busy, pend_nz, ovf, m_pulse(), m_id, m_busy(), m_pend(), m_ovf);
            end
        end
        n_cmp++;
        if (npulse != 4) begin
            n_err++;
            $display("FAIL rr_count: got %0d pulses, want 4", npulse);
        end
    endtask

    task automatic test_saturation();
        int npulse;
        int last_p;
        bit bad;
        do_reset();
        en  = 1'b0;
        req = 4'b0100;
        for (int k = 0; k < 17; k++) tick();
        req = '0;
        n_cmp++;
        if (ovf !== 4'b0100 || pend_nz !== 4'b0100) begin
            n_err++;
            $display("FAIL sat_flags: got ovf=%b pend=%b, want 0100/0100", ovf, pend_nz);
        end
        en     = 1'b1;
        npulse = 0;
        last_p = -100;
        bad    = 0;
        for (int k = 0; k < 15 * GAP + 20; k++) begin
            tick();
            if (tx_pulse === 1'b1) begin
                if (tx_id !== 2'd2 || (npulse > 0 && cyc - last_p != GAP)) bad = 1;
                last_p = cyc;
                npulse++;
            end
        end
        n_cmp++;
        if (npulse != 15 || bad) begin
            n_err++;
            $display("FAIL sat_drain: got %0d pulses (id/spacing bad=%0d), want 15 id=2 spaced %0d",
                     npulse, bad, GAP);
        end
        n_cmp++;
        if (ovf !== 4'b0100 || pend_nz !== '0) begin
            n_err++;
            $display("FAIL sat_sticky: got ovf=%b pend=%b, want 0100/0000", ovf, pend_nz);
        end
        ovf_clr = 4'b0100;
        tick();
        ovf_clr = '0;
        n_cmp++;
        if (ovf !== 4'b0000) begin
            n_err++;
            $display("FAIL sat_clear: got ovf=%b, want 0000", ovf);
        end
    endtask

    task automatic test_simul();
        int t;
        do_reset();
        req = 4'b0010;
        t   = cyc;
        tick();
        tick();
        req = '0;
        n_cmp++;
        if (tx_pulse !== 1'b1 || tx_id !== 2'd1 || pend_nz !== 4'b0010) begin
            n_err++;
            $display("FAIL simul_first: got pulse=%b id=%0d pend=%b, want 1/1/0010", tx_pulse, tx_id, pend_nz);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (tx_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL simul_gap cyc+%0d: got pulse=%b, want 0", cyc - t, tx_pulse);
            end
        end
        tick();
        n_cmp++;
        if (tx_pulse !== 1'b1 || tx_id !== 2'd1) begin
            n_err++;
            $display("FAIL simul_second: got pulse=%b id=%0d at cyc+%0d, want 1/1 at cyc+8",
                     tx_pulse, tx_id, cyc - t);
        end
        tick();
        n_cmp++;
        if (pend_nz !== '0) begin
            n_err++;
            $display("FAIL simul_drained: got pend=%b, want 0000", pend_nz);
        end
    endtask

    task automatic test_reset_mid_hold();
        int npulse;
        do_reset();
        req = 4'b1111;
        tick();
        req = '0;
        tick();
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b1 || pend_nz !== 4'b1110) begin
            n_err++;
            $display("FAIL rmh_pre: got busy=%b pend=%b, want 1/1110", busy, pend_nz);
        end
        wr_reset = 1'b1;
        #1;
        n_cmp++;
        if ({tx_pulse, tx_id, busy, pend_nz, ovf} !== '0) begin
            n_err++;
            $display("FAIL rmh_async: got pulse=%b id=%0d busy=%b pend=%b ovf=%b, want all 0",
                     tx_pulse, tx_id, busy, pend_nz, ovf);
        end
        tick();
        wr_reset = 1'b0;
        npulse   = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (tx_pulse !== 1'b0) npulse++;
        end
        n_cmp++;
        if (npulse != 0 || pend_nz !== '0) begin
            n_err++;
            $display("FAIL rmh_quiet: got %0d pulses pend=%b, want 0/0000", npulse, pend_nz);
        end
    endtask

    task automatic test_enable();
        int npulse;
        do_reset();
        en  = 1'b0;
        req = 4'b1000;
        tick();
        req    = '0;
        npulse = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (tx_pulse !== 1'b0) npulse++;
        end
        n_cmp++;
        if (npulse != 0 || pend_nz !== 4'b1000) begin
            n_err++;
            $display("FAIL en_blocked: got %0d pulses pend=%b, want 0/1000", npulse, pend_nz);
        end
        en = 1'b1;
        tick();
        n_cmp++;
        if (tx_pulse !== 1'b1 || tx_id !== 2'd3) begin
            n_err++;
            $display("FAIL en_release: got pulse=%b id=%0d, want 1/3", tx_pulse, tx_id);
        end
    endtask

    task automatic test_random();
        int last_p;
        do_reset();
        last_p = -100;
        for (int k = 0; k < 900; k++) begin
            n_cmp++;
            if ({tx_pulse, tx_id, busy, pend_nz, ovf} !== {m_pulse(), IW'(m_id), m_busy(), m_pend(), m_ovf}) begin
                n_err++;
                $display("FAIL rand_model step %0d: got %b %0d %b %b %b, want %b %0d %b %b %b", k,
                         tx_pulse, tx_id, busy, pend_nz, ovf, m_pulse(), m_id, m_busy(), m_pend(), m_ovf);
            end
            if (tx_pulse === 1'b1) begin
                n_cmp++;
                if (cyc - last_p < GAP) begin
                    n_err++;
                    $display("FAIL rand_spacing: got gap %0d, want >= %0d", cyc - last_p, GAP);
                end
                last_p = cyc;
            end
            if (k < 400) begin
                req = N'($urandom);
                en  = ($urandom_range(0, 9) < 3);
            end else begin
                req = N'($urandom & $urandom & $urandom);
                en  = ($urandom_range(0, 9) != 0);
            end
            ovf_clr = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            tick();
        end
        req     = '0;
        ovf_clr = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_saturation();
        test_simul();
        test_reset_mid_hold();
        test_enable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
